// File: rtl/pattern_detect_pkg.sv
// Shared constants and helper functions for the parametrised pattern detector.
package pattern_detect_pkg;

  // Configuration that is active after reset.
  localparam logic [5:0] DEF_PATTERN = 6'b110101;
  localparam int         DEF_LEN     = 6;
  localparam bit         DEF_OVERLAP = 1'b1;

  // Widest pattern the mask helper can describe.
  localparam int MAX_W = 32;

  // Returns a mask with the low len bits set. The width argument limits the mask to the history width.
  function automatic logic [MAX_W-1:0] len_mask(input int len, input int width);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < len && i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

  // A length of zero, or one longer than the history, selects the full width.
  function automatic int clamp_len(input int len, input int width);
    return (len <= 0 || len > width) ? width : len;
  endfunction

endpackage

// File: rtl/pattern_detect_param_sat_counter.sv
// Saturating up-counter with a synchronous clear and an asynchronous active-low reset.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  // The count advances on inc, holds at all-ones, and clr takes priority over inc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pattern_detect_param.sv
// Serial pattern detector. It compares a sliding bit history against a runtime-loadable pattern.
module pattern_detect_param
  import pattern_detect_pkg::*;
#(
  parameter int               WIDTH         = 6,
  parameter int               CNT_W         = 8,
  parameter logic [WIDTH-1:0] RESET_PATTERN = WIDTH'(DEF_PATTERN),
  parameter int               RESET_LEN     = DEF_LEN,
  parameter bit               RESET_OVERLAP = DEF_OVERLAP,
  localparam int              LW            = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_pattern,
  input  logic [LW-1:0]    cfg_len,
  input  logic             cfg_overlap,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  logic [WIDTH-1:0] hist_reg, pat_reg;
  logic [LW-1:0]    fill_reg, len_reg;
  logic             ovl_reg, out_reg, armed_reg;

  logic [WIDTH-1:0] hist_next, mask;
  logic [LW-1:0]    fill_inc, fill_next, cfg_len_clamped;
  logic             hit;

  assign cfg_len_clamped = LW'(clamp_len(int'(cfg_len), WIDTH));

  // Shift in the candidate bit, advance fill (saturating at len) and test the masked history against the pattern.
  always_comb begin
    hist_next = {hist_reg[WIDTH-2:0], in};
    fill_inc  = (fill_reg >= len_reg) ? len_reg : fill_reg + 1'b1;
    mask      = WIDTH'(len_mask(int'(len_reg), WIDTH));
    hit       = in_valid && !cfg_load && (fill_inc == len_reg) &&
                (((hist_next ^ pat_reg) & mask) == '0);
    // In non-overlapping mode a hit consumes its bits, so the next match needs len fresh samples.
    fill_next = (hit && !ovl_reg) ? '0 : fill_inc;
  end

  // History, fill, configuration and the registered out/armed flags. cfg_load takes priority and flushes the detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_reg   <= RESET_PATTERN;
      len_reg   <= LW'(clamp_len(RESET_LEN, WIDTH));
      ovl_reg   <= RESET_OVERLAP;
      hist_reg  <= '0;
      fill_reg  <= '0;
      out_reg   <= 1'b0;
      armed_reg <= 1'b0;
    end else if (cfg_load) begin
      pat_reg   <= cfg_pattern;
      len_reg   <= cfg_len_clamped;
      ovl_reg   <= cfg_overlap;
      hist_reg  <= '0;
      fill_reg  <= '0;
      out_reg   <= 1'b0;
      armed_reg <= 1'b0;
    end else if (in_valid) begin
      hist_reg  <= hist_next;
      fill_reg  <= fill_next;
      out_reg   <= hit;
      armed_reg <= (fill_next == len_reg);
    end else begin
      out_reg   <= 1'b0;
    end
  end

  // hit already excludes the cfg_load cycle, so the clear and the increment never coincide.
  sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cfg_load),
    .inc   (hit),
    .count (match_cnt)
  );

  assign out   = out_reg;
  assign armed = armed_reg;

endmodule

// File: tb/tb_pattern_detect_param.sv
// Scoreboard bench for pattern_detect_param. A bit-queue reference model drives expectations and a monitor checks them.
module tb_pattern_detect_param;

  localparam int WIDTH = 6;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(WIDTH + 1);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in = 1'b0;
  logic             in_valid = 1'b0;
  logic             cfg_load = 1'b0;
  logic [WIDTH-1:0] cfg_pattern = '0;
  logic [LW-1:0]    cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic             out;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;

  pattern_detect_param #(
    .WIDTH         (WIDTH),
    .CNT_W         (CNT_W),
    .RESET_PATTERN (6'b110101),
    .RESET_LEN     (6),
    .RESET_OVERLAP (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in),
    .in_valid    (in_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .out         (out),
    .match_cnt   (match_cnt),
    .armed       (armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic o;
    int   c;
    logic a;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  // Reference model: the received bits since the last flush, plus the active configuration.
  bit   seen[$];
  int   m_pat;
  int   m_len;
  bit   m_ovl;
  int   m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    seen.delete();
    m_pat = 'b110101;
    m_len = 6;
    m_ovl = 1'b1;
    m_cnt = 0;
  endtask

  // Present one sample (or an idle cycle) and record the expected response.
  task automatic drive(input bit v, input bit b);
    exp_t e;
    bit   match;
    @(negedge clk);
    cfg_load = 1'b0;
    in_valid = v;
    in       = b;
    e.o = 1'b0;
    if (v) begin
      seen.push_back(b);
      if (seen.size() > WIDTH) seen = seen[1:$];
      match = 1'b0;
      if (seen.size() >= m_len) begin
        match = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (seen[seen.size() - m_len + i] != m_pat[m_len - 1 - i]) match = 1'b0;
      end
      if (match) begin
        e.o = 1'b1;
        if (m_cnt < CMAX) m_cnt++;
        if (!m_ovl) seen.delete();
      end
    end
    e.c = m_cnt;
    e.a = (seen.size() >= m_len);
    q.push_back(e);
  endtask

  // Load a new configuration. A random sample presented in the same cycle must be ignored.
  task automatic cfg(input int p, input int l, input bit o);
    exp_t e;
    @(negedge clk);
    cfg_load    = 1'b1;
    in_valid    = 1'($urandom_range(0, 1));
    in          = 1'($urandom_range(0, 1));
    cfg_pattern = WIDTH'(p);
    cfg_len     = LW'(l);
    cfg_overlap = o;
    m_pat = p;
    m_len = (l == 0 || l > WIDTH) ? WIDTH : l;
    m_ovl = o;
    m_cnt = 0;
    seen.delete();
    e.o = 1'b0;
    e.c = 0;
    e.a = 1'b0;
    q.push_back(e);
  endtask

  // Drive n valid bits, MSB of bits first.
  task automatic stream(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b1, bits[i]);
  endtask

  // Pull reset low between clock edges and confirm the outputs clear without a clock edge.
  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 1'b0;
    cfg_load = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_out", int'(out), 0);
    chk("async_rst_cnt", int'(match_cnt), 0);
    chk("async_rst_armed", int'(armed), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: after each rising edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst && q.size() > 0) begin
        e = q.pop_front();
        txn++;
        chk("out", int'(out), int'(e.o));
        chk("match_cnt", int'(match_cnt), e.c);
        chk("armed", int'(armed), int'(e.a));
        $display("txn %0d: out=%0d cnt=%0d armed=%0d exp out=%0d cnt=%0d armed=%0d",
                 txn, out, match_cnt, armed, e.o, e.c, e.a);
      end
    end
  end

  initial begin
    int w;
    model_reset();
    #3;
    chk("reset_out", int'(out), 0);
    chk("reset_cnt", int'(match_cnt), 0);
    chk("reset_armed", int'(armed), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // The default pattern matches after samples 6 and 12.
    stream(32'b1101011101011, 13);

    // 101 in overlapping mode, then in non-overlapping mode.
    cfg('b101, 3, 1'b1);
    stream(32'b10101, 5);
    cfg('b101, 3, 1'b0);
    stream(32'b10101, 5);

    // Idle cycles inside the default pattern do not break it.
    cfg('b110101, 6, 1'b1);
    stream(32'b110, 3);
    repeat (3) drive(1'b0, 1'($urandom_range(0, 1)));
    stream(32'b101, 3);

    // len=1 with pattern 1: a pulse every cycle and the counter saturates.
    cfg('b1, 1, 1'b1);
    for (int i = 0; i < CMAX + 20; i++) drive(1'b1, 1'b1);

    // cfg_len=0 selects the full width. Reset lands while out is high.
    cfg('b110101, 0, 1'b1);
    stream(32'b110101, 6);
    pulse_reset();
    stream(32'b1101, 4);
    pulse_reset();
    stream(32'b01, 2);

    // Random traffic with occasional reconfiguration, including out-of-range lengths.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 3)
        cfg(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      else
        drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    in_valid = 1'b0;
    cfg_load = 1'b0;

    w = 0;
    while (q.size() > 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
